// File: rtl/display_scheduler.sv
// Arbitrates the 4-digit 7-segment display between clock, alarm and countdown sources,
// with fixed priority, a minimum dwell before preemption, per-source blink and the scan tick.
module display_scheduler #(
  parameter int SCAN_DIV  = 100000,
  parameter int MIN_HOLD  = 1000,
  parameter int BLINK_DIV = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [15:0] dat0,
  input  logic [15:0] dat1,
  input  logic [15:0] dat2,
  input  logic [2:0]  blink,
  output logic [15:0] big_bin,
  output logic [3:0]  an_mask,
  output logic        scan_tick,
  output logic [2:0]  grant
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HW = $clog2(MIN_HOLD + 1);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0] PRE_LAST   = PW'(SCAN_DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(MIN_HOLD);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic {ST_IDLE, ST_OWN} state_t;

  state_t         r_state;
  logic [2:0]     r_grant;
  logic [PW-1:0]  r_pre;
  logic           r_scan_tick;
  logic [HW-1:0]  r_hold;
  logic [BW-1:0]  r_bcnt;
  logic           r_phase;
  logic [15:0]    r_big_bin;
  logic [3:0]     r_an_mask;

  logic [2:0]     w_winner;
  logic           w_owner_req;
  logic           w_higher;
  logic           w_hold_done;
  logic [15:0]    w_dat_sel;
  logic           w_blank;

  function automatic logic [2:0] f_winner(input logic [2:0] r);
    if (r[2])      return 3'b100;
    else if (r[1]) return 3'b010;
    else if (r[0]) return 3'b001;
    else           return 3'b000;
  endfunction

  // One-hot grant with bit 2 highest, so a numerically larger winner is higher priority.
  assign w_winner    = f_winner(req);
  assign w_owner_req = |(req & r_grant);
  assign w_higher    = (w_winner > r_grant);
  assign w_hold_done = (r_hold >= HOLD_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre       <= '0;
      r_scan_tick <= 1'b0;
    end else begin
      r_scan_tick <= (r_pre == PRE_LAST);
      if (r_pre == PRE_LAST) r_pre <= '0;
      else                   r_pre <= r_pre + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_grant <= 3'b000;
      r_hold  <= '0;
      r_bcnt  <= '0;
      r_phase <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req != 3'b000) begin
            r_state <= ST_OWN;
            r_grant <= w_winner;
            r_hold  <= '0;
            r_bcnt  <= '0;
            r_phase <= 1'b0;
          end
        end
        ST_OWN: begin
          if (!w_owner_req) begin
            // Owner released: hand over at once (no dwell check) or fall idle.
            r_state <= (req != 3'b000) ? ST_OWN : ST_IDLE;
            r_grant <= w_winner;
            r_hold  <= '0;
            r_bcnt  <= '0;
            r_phase <= 1'b0;
          end else if (w_higher && w_hold_done) begin
            r_grant <= w_winner;
            r_hold  <= '0;
            r_bcnt  <= '0;
            r_phase <= 1'b0;
          end else if (r_scan_tick) begin
            if (!w_hold_done) r_hold <= r_hold + 1'b1;
            if (r_bcnt == BLINK_LAST) begin
              r_bcnt  <= '0;
              r_phase <= ~r_phase;
            end else begin
              r_bcnt <= r_bcnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= 3'b000;
        end
      endcase
    end
  end

  always_comb begin
    w_dat_sel = 16'h0000;
    case (r_grant)
      3'b001:  w_dat_sel = dat0;
      3'b010:  w_dat_sel = dat1;
      3'b100:  w_dat_sel = dat2;
      default: w_dat_sel = 16'h0000;
    endcase
  end

  assign w_blank = (r_state == ST_IDLE) || ((|(blink & r_grant)) && r_phase);

  // Datapath resamples live data and blink every clk: one clk behind the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_big_bin <= 16'h0000;
      r_an_mask <= 4'hF;
    end else begin
      r_big_bin <= w_dat_sel;
      r_an_mask <= w_blank ? 4'hF : 4'h0;
    end
  end

  assign big_bin   = r_big_bin;
  assign an_mask   = r_an_mask;
  assign scan_tick = r_scan_tick;
  assign grant     = r_grant;

endmodule

// File: tb/tb_display_scheduler.sv
// Bench for display_scheduler: directed sequences, a vector table and a randomized
// run against a tick-counting reference model.
module tb_display_scheduler;

  localparam int SCAN_DIV  = 4;
  localparam int MIN_HOLD  = 3;
  localparam int BLINK_DIV = 2;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic [15:0] dat0, dat1, dat2;
  logic [2:0]  blink;
  logic [15:0] big_bin;
  logic [3:0]  an_mask;
  logic        scan_tick;
  logic [2:0]  grant;

  int checks = 0;
  int errors = 0;

  display_scheduler #(
    .SCAN_DIV (SCAN_DIV),
    .MIN_HOLD (MIN_HOLD),
    .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .dat0     (dat0),
    .dat1     (dat1),
    .dat2     (dat2),
    .blink    (blink),
    .big_bin  (big_bin),
    .an_mask  (an_mask),
    .scan_tick(scan_tick),
    .grant    (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [2:0]  req;
    int          waits;
    logic [2:0]  g;
    logic [15:0] bb;
    logic [3:0]  an;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two negedges, release between clock edges.
  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model state
  int m_owner;
  int m_ticks;
  bit m_prevtick;
  int m_n;

  function automatic logic [2:0] onehot(input int o);
    return (o < 0) ? 3'b000 : 3'(1 << o);
  endfunction

  initial begin
    rst_n = 1'b0;
    req   = 3'b000;
    blink = 3'b000;
    dat0  = 16'h0000;
    dat1  = 16'h0000;
    dat2  = 16'h0000;

    // ---- Reset with all sources requesting, then async reset mid-cycle
    req  = 3'b111;
    dat0 = 16'h1234; dat1 = 16'h5678; dat2 = 16'h9ABC;
    @(negedge clk);
    chk("rst_grant", 16'(grant), 16'h0000);
    chk("rst_an", 16'(an_mask), 16'h000F);
    chk("rst_bb", big_bin, 16'h0000);
    chk("rst_tick", 16'(scan_tick), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("t1_grant", 16'(grant), 16'h0004);
    chk("t1_bb_lag", big_bin, 16'h0000);
    chk("t1_an_lag", 16'(an_mask), 16'h000F);
    step();
    chk("t1_bb", big_bin, 16'h9ABC);
    chk("t1_an", 16'(an_mask), 16'h0000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_grant", 16'(grant), 16'h0000);
    chk("async_bb", big_bin, 16'h0000);
    chk("async_an", 16'(an_mask), 16'h000F);

    // ---- Prescaler
    req = 3'b000;
    do_reset();
    for (int e = 1; e <= 20; e++) begin
      step();
      chk($sformatf("tick_e%0d", e), 16'(scan_tick), (e % 4 == 0) ? 16'h1 : 16'h0);
    end

    // ---- Hold then preempt by source 2
    req = 3'b000; dat0 = 16'h1234; dat2 = 16'hBEEF;
    do_reset();
    req = 3'b001;
    step();
    chk("t3_grant0", 16'(grant), 16'h0001);
    for (int e = 2; e <= 5; e++) step();
    req = 3'b101;
    for (int e = 6; e <= 13; e++) begin
      step();
      chk($sformatf("t3_hold_g_e%0d", e), 16'(grant), 16'h0001);
      chk($sformatf("t3_hold_bb_e%0d", e), big_bin, 16'h1234);
    end
    step();
    chk("t3_preempt_g", 16'(grant), 16'h0004);
    chk("t3_preempt_bb", big_bin, 16'h1234);
    step();
    chk("t3_new_bb", big_bin, 16'hBEEF);

    // ---- Release / lower priority table
    tbl[0]  = '{req: 3'b010, waits: 1,  g: 3'b010, bb: 16'h0000, an: 4'hF};
    tbl[1]  = '{req: 3'b010, waits: 1,  g: 3'b010, bb: 16'h2222, an: 4'h0};
    tbl[2]  = '{req: 3'b011, waits: 1,  g: 3'b010, bb: 16'h2222, an: 4'h0};
    tbl[3]  = '{req: 3'b001, waits: 1,  g: 3'b001, bb: 16'h2222, an: 4'h0};
    tbl[4]  = '{req: 3'b001, waits: 1,  g: 3'b001, bb: 16'h1111, an: 4'h0};
    tbl[5]  = '{req: 3'b000, waits: 1,  g: 3'b000, bb: 16'h1111, an: 4'h0};
    tbl[6]  = '{req: 3'b000, waits: 1,  g: 3'b000, bb: 16'h0000, an: 4'hF};
    tbl[7]  = '{req: 3'b100, waits: 1,  g: 3'b100, bb: 16'h0000, an: 4'hF};
    tbl[8]  = '{req: 3'b110, waits: 20, g: 3'b100, bb: 16'h3333, an: 4'h0};
    tbl[9]  = '{req: 3'b010, waits: 1,  g: 3'b010, bb: 16'h3333, an: 4'h0};
    tbl[10] = '{req: 3'b010, waits: 1,  g: 3'b010, bb: 16'h2222, an: 4'h0};
    req = 3'b000; blink = 3'b000;
    dat0 = 16'h1111; dat1 = 16'h2222; dat2 = 16'h3333;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      req = tbl[i].req;
      repeat (tbl[i].waits) step();
      chk($sformatf("tbl%0d_grant", i), 16'(grant), 16'(tbl[i].g));
      chk($sformatf("tbl%0d_bb", i), big_bin, tbl[i].bb);
      chk($sformatf("tbl%0d_an", i), 16'(an_mask), 16'(tbl[i].an));
    end

    // ---- Blink
    req = 3'b000; blink = 3'b000; dat0 = 16'h4321;
    do_reset();
    req = 3'b001; blink = 3'b001;
    step();
    chk("t5_grant", 16'(grant), 16'h0001);
    for (int e = 2; e <= 27; e++) begin
      step();
      chk($sformatf("t5_an_e%0d", e), 16'(an_mask),
          ((e >= 10 && e <= 17) || e >= 26) ? 16'h000F : 16'h0000);
    end
    blink = 3'b000;
    step();
    chk("t5_unblank", 16'(an_mask), 16'h0000);

    // ---- Simultaneous release and higher request
    req = 3'b001; blink = 3'b000; dat0 = 16'hAAAA; dat1 = 16'hBBBB; dat2 = 16'hCCCC;
    do_reset();
    step();
    chk("t6_grant0", 16'(grant), 16'h0001);
    for (int e = 2; e <= 5; e++) step();
    req = 3'b110;
    step();
    chk("t6_grant2", 16'(grant), 16'h0004);
    step();
    chk("t6_bb", big_bin, 16'hCCCC);

    // ---- Randomized run against reference model
    req = 3'b000; blink = 3'b000;
    do_reset();
    m_owner = -1; m_ticks = 0; m_prevtick = 1'b0; m_n = 0;
    for (int c = 0; c < 3000; c++) begin
      logic [15:0] e_bb;
      logic [3:0]  e_an;
      int          w;
      int          held;
      if ($urandom_range(0, 5) == 0)  req   = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) blink = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0)  dat0  = 16'($urandom);
      if ($urandom_range(0, 1) == 0)  dat1  = 16'($urandom);
      if ($urandom_range(0, 1) == 0)  dat2  = 16'($urandom);
      e_bb = (m_owner == 0) ? dat0 : (m_owner == 1) ? dat1 : (m_owner == 2) ? dat2 : 16'h0000;
      if (m_owner < 0) e_an = 4'hF;
      else e_an = (blink[m_owner] && ((m_ticks / BLINK_DIV) % 2 == 1)) ? 4'hF : 4'h0;
      w = req[2] ? 2 : req[1] ? 1 : req[0] ? 0 : -1;
      held = (m_ticks < MIN_HOLD) ? m_ticks : MIN_HOLD;
      @(posedge clk);
      if (m_owner < 0) begin
        if (w >= 0) begin m_owner = w; m_ticks = 0; end
      end else if (!req[m_owner]) begin
        m_owner = w; m_ticks = 0;
      end else if (w > m_owner && held >= MIN_HOLD) begin
        m_owner = w; m_ticks = 0;
      end else if (m_prevtick) begin
        m_ticks++;
      end
      m_n++;
      m_prevtick = (m_n % SCAN_DIV == 0);
      #1;
      chk("rnd_grant", 16'(grant), 16'(onehot(m_owner)));
      chk("rnd_bb", big_bin, e_bb);
      chk("rnd_an", 16'(an_mask), 16'(e_an));
      chk("rnd_tick", 16'(scan_tick), 16'(m_prevtick));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
- Time-shares the 4-digit 7-segment display between three requesters: 0 = clock time, 1 = alarm/set mode, 2 = countdown/alert message.
- Drives the 16-bit value consumed by the nibble/anode multiplexer.
- Generates that multiplexer's scan tick.
- Provides per-digit blanking (blink) and a minimum dwell time, so the display does not flicker between sources.

Parameters:
- SCAN_DIV, 100000: clk cycles per scan_tick (1 kHz from 100 MHz); legal values >= 2.
- MIN_HOLD, 1000: scan ticks a grant must be held before a higher-priority source may preempt it; legal values >= 1.
- BLINK_DIV, 500: scan ticks per blink half-period; legal values >= 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  3  per-source display request, bit i = source i, level-sensitive
- dat0  in  16  source 0 display value (4 BCD nibbles, [15:12] = leftmost digit)
- dat1  in  16  source 1 display value
- dat2  in  16  source 2 display value
- blink  in  3  per-source blink enable, bit i = source i
- big_bin  out  16  registered value to the display multiplexer
- an_mask  out  4  active-high digit blank; OR this into the active-low AN lines
- scan_tick  out  1  one-clk pulse at scan rate; clocks/enables the multiplexer
- grant  out  3  one-hot current owner; 3'b000 when idle

Behaviour:
Reset:
- rst_n low forces the following immediately, independent of clk: prescaler = 0, hold counter = 0, blink counter = 0, blink phase = 0, state = IDLE.
- Reset output values: grant = 000, big_bin = 16'h0000, an_mask = 4'hF, scan_tick = 0.
- Asserting reset mid-grant abandons the grant. There is no recovery of prior state.

Prescaler:
- Counts 0..SCAN_DIV-1 and wraps to 0.
- scan_tick is registered and is high for exactly one clk in the cycle after the count equals SCAN_DIV-1. Period = SCAN_DIV clks.

State machine (states IDLE, OWN), evaluated on every clk edge:
- Priority is fixed: source 2 > 1 > 0. "Winner" = the highest-priority source with req set.
- IDLE, req != 0:
  - go to OWN with grant = winner.
  - hold counter = 0, blink counter = 0, phase = 0.
- OWN(s), req[s] drops:
  - If any other req is set, re-grant to the winner in the same edge. Counters are cleared as for a new grant.
  - Otherwise go to IDLE.
- OWN(s), req[s] still set, higher-priority source requesting:
  - If hold counter >= MIN_HOLD, switch the grant to the winner and clear the counters.
  - Otherwise keep s.
- Lower-priority requests never preempt.
- Simultaneous events: if req[s] drops and a higher source asserts on the same edge, re-grant immediately to the winner. The hold time is not checked, because the owner released.

Counters (all advance only on cycles where scan_tick is high):
- Hold counter:
  - increments while in OWN.
  - saturates at MIN_HOLD; it never wraps.
- Blink counter:
  - increments while in OWN.
  - when it reaches BLINK_DIV-1, it wraps to 0 and toggles phase.

Datapath (one clk latency from grant/dat to big_bin):
- big_bin = dat of the granted source, resampled every clk, so live updates pass through.
- In IDLE, big_bin = 16'h0000.
- an_mask = 4'hF when IDLE.
- an_mask = 4'hF when blink[s] = 1 and phase = 1.
- an_mask = 4'h0 otherwise.
- blink is sampled live; deasserting it unblanks on the next clk.

Invariants:
- grant is always one-hot or zero.
- grant[i] = 1 implies req[i] was 1 on the previous edge.

Test Plan:
Bench parameters: SCAN_DIV=4, MIN_HOLD=3, BLINK_DIV=2.
1. Reset with req=111 held: release rst_n -> grant=000, an_mask=F during reset; 1 clk after release grant=100, and big_bin=dat2 on the following clk. Assert rst_n=0 asynchronously mid-cycle -> outputs return to reset values with no clk edge.
2. Prescaler: free-run 20 clks -> scan_tick high exactly at clks 4, 8, 12, 16, 20 after reset, one cycle wide each.
3. Hold/preempt: grant src0 (dat0=16'h1234), then assert req[2] after 1 scan tick -> grant stays 001 and big_bin stays 1234 until the 3rd scan tick since grant. On the next edge grant=100, then big_bin=dat2.
4. Release: while src1 owns (grant=010), drop req[1] with req[0]=1 -> next edge grant=001 immediately, with no hold wait. Then drop req[0] -> grant=000, big_bin=0000, an_mask=F.
5. Blink: src0 owns, blink[0]=1 -> an_mask toggles 0 -> F -> 0 every 2 scan ticks (8 clks). Clear blink[0] while an_mask=F -> an_mask=0 on the next clk.
6. Simultaneous: src0 owns with hold=1 (not expired); in one edge drop req[0] and raise req[1] and req[2] -> grant=100, hold counter=0.
